// File: rtl/oh_debounce_pkg.sv
// Shared types and limits for the oh_debounce input conditioner.
package oh_debounce_pkg;

  localparam int SYNCPIPE_MIN = 2;
  localparam int SYNCPIPE_MAX = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/oh_debounce_bit.sv
// One debounced bit: synchronizer, stability counter and out/rise/fall registers.
//   state | meaning
//   IDLE  | synchronized input matches out, counter at 0
//   COUNT | mismatch seen, counting stable cycles toward cfg_count
module oh_debounce_bit
  import oh_debounce_pkg::*;
#(
  parameter int SYNCPIPE = 2,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic [CW-1:0] cfg_count,
  input  logic          in,
  output logic          sync,
  output logic          out,
  output logic          rise,
  output logic          fall
);

  generate
    if (SYNCPIPE < SYNCPIPE_MIN || SYNCPIPE > SYNCPIPE_MAX) begin : g_bad_syncpipe
      $error("oh_debounce_bit: SYNCPIPE must be within 2..4");
    end
  endgenerate

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          out_next, rise_next, fall_next;

  oh_dsync #(.N(SYNCPIPE)) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .din    (in),
    .dout   (sync)
  );

  // The IDLE edge that first sees a mismatch already counts, so cfg_count=0
  // commits on that same edge; >= lets a lowered cfg_count finish immediately.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    out_next   = out;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (!en || sync == out) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (cnt >= cfg_count) begin
      state_next = IDLE;
      cnt_next   = '0;
      out_next   = sync;
      rise_next  = sync;
      fall_next  = ~sync;
    end else begin
      state_next = COUNT;
      cnt_next   = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      out   <= out_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

endmodule

// File: rtl/oh_dsync.sv
// Plain N-flop level synchronizer with asynchronous active-low clear.
module oh_dsync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic din,
  output logic dout
);

  logic [N-1:0] pipe;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) pipe <= '0;
    else         pipe <= {pipe[N-2:0], din};
  end

  assign dout = pipe[N-1];

endmodule

// File: rtl/oh_debounce.sv
// Parallel per-bit debouncer: DW independent filters sharing cfg_count and en.
module oh_debounce
  import oh_debounce_pkg::*;
#(
  parameter int DW       = 1,
  parameter int SYNCPIPE = 2,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic [CW-1:0] cfg_count,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
  output logic [DW-1:0] rise,
  output logic [DW-1:0] fall,
  output logic          busy
);

  logic [DW-1:0] sync;

  for (genvar i = 0; i < DW; i++) begin : g_bit
    oh_debounce_bit #(
      .SYNCPIPE (SYNCPIPE),
      .CW       (CW)
    ) u_bit (
      .clk       (clk),
      .nreset    (nreset),
      .en        (en),
      .cfg_count (cfg_count),
      .in        (in[i]),
      .sync      (sync[i]),
      .out       (out[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

  assign busy = |((sync ^ out) & {DW{en}});

endmodule

// File: tb/tb_oh_debounce.sv
// Directed and model-checked bench for oh_debounce (DW=4, SYNCPIPE=2, CW=8).
module tb_oh_debounce;

  logic       clk = 1'b0;
  logic       nreset;
  logic       en;
  logic [7:0] cfg;
  logic [3:0] din, dout, rise, fall;
  logic       busy;
  int         vecs = 0;
  int         errs = 0;

  oh_debounce #(.DW(4), .SYNCPIPE(2), .CW(8)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .en        (en),
    .cfg_count (cfg),
    .in        (din),
    .out       (dout),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [7:0] c, input logic [3:0] v);
    cfg = c; din = v; en = 1'b1;
    step(int'(c) + 8);
  endtask

  task automatic test_reset();
    nreset = 1'b0; en = 1'b1; cfg = 8'd3; din = 4'hF;
    #12;
    vecs++;
    if ({dout, rise, fall, busy} !== 13'd0) begin
      errs++; $display("FAIL reset_hold: out=%h rise=%h fall=%h busy=%b want all 0", dout, rise, fall, busy);
    end
    @(posedge clk); #1;
    nreset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      vecs++;
      if (dout !== (k >= 6 ? 4'hF : 4'h0) || rise !== (k == 6 ? 4'hF : 4'h0) ||
          busy !== (k >= 2 && k < 6) || fall !== 4'h0) begin
        errs++; $display("FAIL reset_release edge %0d: out=%h rise=%h fall=%h busy=%b", k, dout, rise, fall, busy);
      end
    end
  endtask

  task automatic test_glitch();
    settle(8'd3, 4'h0);
    din[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k == 3) din[0] = 1'b0;
      vecs++;
      if (dout[0] !== 1'b0 || rise[0] !== 1'b0) begin
        errs++; $display("FAIL glitch_reject edge %0d: out0=%b rise0=%b want 0 0", k, dout[0], rise[0]);
      end
    end
    din[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      if (k == 4) din[0] = 1'b0;
      vecs++;
      if (dout[0] !== (k >= 6 && k < 10) || rise[0] !== (k == 6) || fall[0] !== (k == 10)) begin
        errs++; $display("FAIL glitch_pass edge %0d: out0=%b rise0=%b fall0=%b", k, dout[0], rise[0], fall[0]);
      end
    end
  endtask

  task automatic test_bounce();
    settle(8'd5, 4'h0);
    din[1] = 1'b1; step(2);
    din[1] = 1'b0; step(2);
    din[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      vecs++;
      if (dout[1] !== (k >= 8) || rise[1] !== (k == 8)) begin
        errs++; $display("FAIL bounce_restart edge %0d: out1=%b rise1=%b", k, dout[1], rise[1]);
      end
    end
  endtask

  task automatic test_cfg_limits();
    settle(8'd0, 4'h0);
    din = 4'h5;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      vecs++;
      if (dout !== (k >= 3 ? 4'h5 : 4'h0) || rise !== (k == 3 ? 4'h5 : 4'h0)) begin
        errs++; $display("FAIL cfg_zero edge %0d: out=%h rise=%h", k, dout, rise);
      end
    end
    settle(8'd0, 4'h0);
    cfg = 8'hFF; din = 4'h1;
    for (int k = 1; k <= 260; k++) begin
      step(1);
      vecs++;
      if (dout !== (k >= 258 ? 4'h1 : 4'h0) || rise !== (k == 258 ? 4'h1 : 4'h0) ||
          busy !== (k >= 2 && k < 258)) begin
        errs++; $display("FAIL cfg_max edge %0d: out=%h rise=%h busy=%b", k, dout, rise, busy);
      end
    end
  endtask

  task automatic test_enable();
    settle(8'd5, 4'h0);
    din[2] = 1'b1;
    step(4);
    en = 1'b0;
    #1;
    vecs++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL enable_busy_drop: busy=%b want 0", busy);
    end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      vecs++;
      if (dout !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || busy !== 1'b0) begin
        errs++; $display("FAIL enable_frozen edge %0d: out=%h rise=%h fall=%h busy=%b", k, dout, rise, fall, busy);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      vecs++;
      if (dout !== (k >= 6 ? 4'h4 : 4'h0) || rise !== (k == 6 ? 4'h4 : 4'h0) || busy !== (k < 6)) begin
        errs++; $display("FAIL enable_restart edge %0d: out=%h rise=%h busy=%b", k, dout, rise, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    din = 4'h0;
    step(3);
    #3;
    nreset = 1'b0;
    #1;
    vecs++;
    if ({dout, rise, fall, busy} !== 13'd0) begin
      errs++; $display("FAIL reset_async: out=%h rise=%h fall=%h busy=%b want all 0", dout, rise, fall, busy);
    end
    din = 4'h1;
    nreset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      vecs++;
      if (dout !== (k >= 8 ? 4'h1 : 4'h0) || rise !== (k == 8 ? 4'h1 : 4'h0)) begin
        errs++; $display("FAIL reset_mid_rise edge %0d: out=%h rise=%h", k, dout, rise);
      end
    end
  endtask

  task automatic test_parallel();
    settle(8'd3, 4'h0);
    din = 4'b1010; step(1);
    din = 4'b0010; step(1);
    din = 4'b1010;
    for (int k = 3; k <= 11; k++) begin
      step(1);
      vecs++;
      if (dout !== {k >= 8, 1'b0, k >= 6, 1'b0} || rise !== {k == 8, 1'b0, k == 6, 1'b0} || fall !== 4'h0) begin
        errs++; $display("FAIL parallel edge %0d: out=%b rise=%b fall=%b", k, dout, rise, fall);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] m_s1, m_s, m_out, m_rise, m_fall;
    int         m_run [4];
    logic       m_busy;
    nreset = 1'b0; din = 4'h0; en = 1'b1; cfg = 8'd2;
    #2;
    nreset = 1'b1;
    @(posedge clk); #1;
    m_s1 = '0; m_s = '0; m_out = '0; m_rise = '0; m_fall = '0;
    for (int b = 0; b < 4; b++) m_run[b] = 0;
    din = 4'h0;
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) cfg = 8'($urandom_range(0, 4));
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) din[b] = ~din[b];
      en = ($urandom_range(0, 15) != 0);
      step(1);
      for (int b = 0; b < 4; b++) begin
        m_rise[b] = 1'b0;
        m_fall[b] = 1'b0;
        if (!en || m_s[b] == m_out[b]) m_run[b] = 0;
        else if (m_run[b] >= int'(cfg)) begin
          m_out[b]  = m_s[b];
          m_rise[b] = m_s[b];
          m_fall[b] = ~m_s[b];
          m_run[b]  = 0;
        end else m_run[b] = m_run[b] + 1;
      end
      m_s  = m_s1;
      m_s1 = din;
      m_busy = en && ((m_s ^ m_out) != 4'h0);
      vecs++;
      if (dout !== m_out || rise !== m_rise || fall !== m_fall || busy !== m_busy) begin
        errs++;
        $display("FAIL random cycle %0d: out=%h rise=%h fall=%h busy=%b want %h %h %h %b",
                 c, dout, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_cfg_limits();
    test_enable();
    test_reset_mid();
    test_parallel();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
